snake_body: RTL and testbench

Per-player snake body register. It advances the snake one cell per game tick in the latched direction and shifts the body. It grows when the food checker reports an eaten food, and it flags wall and self collisions. It sits directly upstream of the food checker and produces that block's `snakeN` body vector and `snake_head` inputs. Its `grow` input is driven from the checker's score increment.

---
 rtl/snake_body_pkg.sv | 27 ++
 rtl/snake_body_next_head_calc.sv | 76 +++++++
 rtl/snake_body.sv | 131 +++++++++++++
 tb/tb_snake_body.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/snake_body_pkg.sv
// Shared types and constants for the snake body register and its head calculator.
// Used by snake_body and next_head_calc.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_UP    = 2'd3
    } dir_e;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } state_e;

    // Wide all-ones value; truncated to the position width it is the unused-segment marker.
    localparam logic [31:0] SENTINEL = '1;

    localparam int WIDTH_DEF  = 32;
    localparam int HEIGHT_DEF = 24;

    function automatic logic [1:0] reverse_of(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_body_next_head_calc.sv
// Combinational next-head position for one step in a given direction.
// Board edges wrap when SNAKE_WRAP_EN is defined, otherwise they raise wall_hit.
module next_head_calc
    import snake_pkg::*;
#(
    parameter int num_len = 10,
    parameter int width   = WIDTH_DEF,
    parameter int height  = HEIGHT_DEF
) (
    input  logic [num_len-1:0] head,
    input  logic [1:0]         dir,
    output logic [num_len-1:0] new_head,
    output logic               wall_hit
);

    localparam logic [num_len-1:0] W = num_len'(width);
    localparam logic [num_len-1:0] H = num_len'(height);

    logic [num_len-1:0] x;
    logic [num_len-1:0] y;

    assign x = head % W;
    assign y = head / W;

    always_comb begin
        new_head = head;
        wall_hit = 1'b0;
        case (dir)
            DIR_RIGHT: begin
                if (x == W - 1'b1) begin
`ifdef SNAKE_WRAP_EN
                    new_head = head - (W - 1'b1);
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    new_head = head + 1'b1;
                end
            end
            DIR_DOWN: begin
                if (y == H - 1'b1) begin
`ifdef SNAKE_WRAP_EN
                    new_head = x;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    new_head = head + W;
                end
            end
            DIR_LEFT: begin
                if (x == '0) begin
`ifdef SNAKE_WRAP_EN
                    new_head = head + (W - 1'b1);
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    new_head = head - 1'b1;
                end
            end
            DIR_UP: begin
                if (y == '0) begin
`ifdef SNAKE_WRAP_EN
                    new_head = head + (H - 1'b1) * W;
`else
                    wall_hit = 1'b1;
`endif
                end else begin
                    new_head = head - W;
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_body.sv
// Per-player snake body: steps on tick, buffers direction, grows on food, flags collisions.
// SNAKE_WRAP_EN (see next_head_calc) makes board edges wrap instead of killing the snake.
module snake_body
    import snake_pkg::*;
#(
    parameter int max_len         = 31,
    parameter int num_len         = 10,
    parameter int max_len_bit_len = 5,
    parameter int width           = WIDTH_DEF,
    parameter int height          = HEIGHT_DEF,
    parameter int init_x          = 4,
    parameter int init_y          = 4,
    parameter int init_len        = 3
) (
    input  logic                       clk_raw,
    input  logic                       rst,
    input  logic                       tick,
    input  logic [1:0]                 dir_in,
    input  logic                       dir_valid,
    input  logic                       grow,
    output logic [max_len*num_len-1:0] snake,
    output logic [num_len-1:0]         snake_head,
    output logic [max_len_bit_len-1:0] length,
    output logic [1:0]                 dir,
    output logic                       moved,
    output logic                       dead
);

    localparam logic [num_len-1:0]         SENT     = num_len'(SENTINEL);
    localparam logic [max_len_bit_len-1:0] LEN_MAX  = max_len_bit_len'(max_len);
    localparam logic [max_len_bit_len-1:0] LEN_INIT = max_len_bit_len'(init_len);

    state_e                     state_q;
    logic [num_len-1:0]         body_q [max_len];
    logic [num_len-1:0]         body_d [max_len];
    logic [max_len_bit_len-1:0] len_q;
    logic [max_len_bit_len-1:0] len_d;
    logic [1:0]                 dir_q;
    logic [1:0]                 pend_q;
    logic [1:0]                 pend_d;
    logic                       grow_pend_q;
    logic                       moved_q;
    logic                       dead_q;
    logic                       req_ok;
    logic                       do_grow;
    logic                       wall_hit;
    logic                       self_hit;
    logic [num_len-1:0]         new_head;
    logic [max_len-1:0]         hit_vec;

    // A request that reverses either the heading or the already-pending turn is dropped,
    // so an earlier legal turn cannot be undone into a U-turn before the tick.
    assign req_ok  = dir_valid && (dir_in != reverse_of(dir_q)) && (dir_in != reverse_of(pend_q));
    assign pend_d  = req_ok ? dir_in : pend_q;
    assign do_grow = (grow_pend_q || grow) && (len_q < LEN_MAX);
    assign len_d   = do_grow ? len_q + 1'b1 : len_q;
    assign self_hit = |hit_vec;

    next_head_calc #(
        .num_len (num_len),
        .width   (width),
        .height  (height)
    ) u_next_head (
        .head     (body_q[0]),
        .dir      (pend_d),
        .new_head (new_head),
        .wall_hit (wall_hit)
    );

    generate
        for (genvar gi = 0; gi < max_len; gi++) begin : g_seg
            localparam logic [max_len_bit_len-1:0] IDX = max_len_bit_len'(gi);
            // The tail cell is vacated on a non-growing step, so it cannot be hit.
            assign hit_vec[gi] = (body_q[gi] == new_head) && (IDX < len_q) &&
                                 (do_grow || (IDX != len_q - 1'b1));
            if (gi == 0) begin : g_head
                assign body_d[gi] = new_head;
            end else begin : g_body
                assign body_d[gi] = (IDX < len_d) ? body_q[gi-1] : SENT;
            end
            assign snake[gi*num_len +: num_len] = body_q[gi];
        end
    endgenerate

    always_ff @(posedge clk_raw or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < max_len; i++) begin
                body_q[i] <= (i < init_len) ? num_len'(init_y*width + init_x - i) : SENT;
            end
            len_q       <= LEN_INIT;
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            moved_q     <= 1'b0;
            dead_q      <= 1'b0;
            state_q     <= RUN;
        end else begin
            moved_q <= 1'b0;
            case (state_q)
                RUN: begin
                    pend_q <= pend_d;
                    if (tick) begin
                        grow_pend_q <= 1'b0;
                        if (wall_hit || self_hit) begin
                            dead_q  <= 1'b1;
                            state_q <= DEAD;
                        end else begin
                            for (int i = 0; i < max_len; i++) begin
                                body_q[i] <= body_d[i];
                            end
                            len_q   <= len_d;
                            dir_q   <= pend_d;
                            moved_q <= 1'b1;
                        end
                    end else if (grow) begin
                        grow_pend_q <= 1'b1;
                    end
                end
                DEAD: begin
                end
            endcase
        end
    end

    assign snake_head = body_q[0];
    assign length     = len_q;
    assign dir        = dir_q;
    assign moved      = moved_q;
    assign dead       = dead_q;

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: stimulus queues expected step results, a monitor checks them.
module tb_snake_body;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic [1:0]   dir_in = 2'd0;
    logic         dir_valid = 1'b0;
    logic         grow = 1'b0;
    logic [309:0] snake;
    logic [9:0]   snake_head;
    logic [4:0]   length;
    logic [1:0]   dir;
    logic         moved;
    logic         dead;

    always #5 clk = ~clk;

    snake_body dut (
        .clk_raw    (clk),
        .rst        (rst),
        .tick       (tick),
        .dir_in     (dir_in),
        .dir_valid  (dir_valid),
        .grow       (grow),
        .snake      (snake),
        .snake_head (snake_head),
        .length     (length),
        .dir        (dir),
        .moved      (moved),
        .dead       (dead)
    );

    typedef struct packed {
        logic [9:0] head;
        logic [4:0] len;
        logic [1:0] dir;
        logic       dead;
        logic [9:0] tail;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic dead_seen = 1'b0;

    function automatic logic [9:0] seg(input int i);
        return snake[i*10 +: 10];
    endfunction

    function automatic exp_t mk(input int h, input int l, input int d, input int dd, input int t);
        exp_t e;
        e.head = 10'(h);
        e.len  = 5'(l);
        e.dir  = 2'(d);
        e.dead = 1'(dd);
        e.tail = 10'(t);
        return e;
    endfunction

    // Monitor: one scoreboard entry per body update or per death event.
    always @(negedge clk) begin
        if (!rst && (moved || (dead && !dead_seen))) begin
            exp_t       e;
            logic [9:0] tl;
            logic [9:0] nx;
            logic       ok;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: head=%0d len=%0d moved=%0b dead=%0b, required no output",
                         snake_head, length, moved, dead);
            end else begin
                e  = exp_q.pop_front();
                tl = seg(int'(length) - 1);
                nx = (length < 5'd31) ? seg(int'(length)) : 10'h3ff;
                ok = (snake_head == e.head) && (seg(0) == e.head) && (length == e.len) &&
                     (dir == e.dir) && (dead == e.dead) && (moved == !e.dead) &&
                     (tl == e.tail) && (nx == 10'h3ff);
                if (!ok) begin
                    fails++;
                    $display("FAIL step: got head=%0d len=%0d dir=%0d dead=%0b moved=%0b tail=%0d next=%0d, required head=%0d len=%0d dir=%0d dead=%0b moved=%0b tail=%0d next=1023",
                             snake_head, length, dir, dead, moved, tl, nx,
                             e.head, e.len, e.dir, e.dead, !e.dead, e.tail);
                end else begin
                    $display("[TB] step head=%0d len=%0d dir=%0d dead=%0b tail=%0d ok",
                             snake_head, length, dir, dead, tl);
                end
            end
        end
        dead_seen = dead;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end else begin
            $display("[TB] check %s = %0d ok", nm, act);
        end
    endtask

    task automatic check_reset();
        logic [309:0] ev;
        for (int i = 0; i < 31; i++) ev[i*10 +: 10] = (i < 3) ? 10'(132 - i) : 10'h3ff;
        chk("rst_head", 32'(snake_head), 132);
        chk("rst_len", 32'(length), 3);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_moved", 32'(moved), 0);
        chk("rst_dead", 32'(dead), 0);
        tests++;
        if (snake !== ev) begin
            fails++;
            $display("FAIL rst_body: got %h, required %h", snake, ev);
        end
    endtask

    // Tick with optional grow/direction; the response must be in the scoreboard one cycle later.
    task automatic step(input logic g, input logic dv, input logic [1:0] d, input exp_t e);
        exp_q.push_back(e);
        tick = 1'b1; grow = g; dir_valid = dv; dir_in = d;
        @(posedge clk); #1;
        tick = 1'b0; grow = 1'b0; dir_valid = 1'b0;
        @(negedge clk); #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL latency: %0d responses outstanding one cycle after tick, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic req(input logic [1:0] d);
        dir_valid = 1'b1; dir_in = d;
        @(posedge clk); #1;
        dir_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic grow_pulse();
        grow = 1'b1;
        @(posedge clk); #1;
        grow = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        check_reset();

        step(1'b0, 1'b0, 2'd0, mk(133, 3, 0, 0, 131));
        req(2'd2);
        step(1'b0, 1'b0, 2'd0, mk(134, 3, 0, 0, 132));
        req(2'd1);
        req(2'd3);
        step(1'b0, 1'b0, 2'd0, mk(166, 3, 1, 0, 133));
        grow_pulse();
        step(1'b0, 1'b0, 2'd0, mk(198, 4, 1, 0, 133));

        // Grow every tick along row 6 towards the right edge, then down the last column.
        step(1'b1, 1'b1, 2'd0, mk(199, 5, 0, 0, 133));
        for (int k = 1; k <= 24; k++) step(1'b1, 1'b0, 2'd0, mk(199 + k, 5 + k, 0, 0, 133));
        step(1'b1, 1'b1, 2'd1, mk(255, 30, 1, 0, 133));
        step(1'b1, 1'b0, 2'd0, mk(287, 31, 1, 0, 133));
        step(1'b1, 1'b0, 2'd0, mk(319, 31, 1, 0, 134));
        step(1'b0, 1'b0, 2'd0, mk(351, 31, 1, 0, 166));
`ifdef SNAKE_WRAP_EN
        step(1'b0, 1'b1, 2'd0, mk(320, 31, 0, 0, 198));
`else
        step(1'b0, 1'b1, 2'd0, mk(351, 31, 1, 1, 166));
`endif
        do_reset();

        // Length-5 loop turning back into its own body.
        step(1'b1, 1'b0, 2'd0, mk(133, 4, 0, 0, 130));
        step(1'b1, 1'b1, 2'd1, mk(165, 5, 1, 0, 130));
        step(1'b0, 1'b1, 2'd2, mk(164, 5, 2, 0, 131));
        step(1'b0, 1'b1, 2'd3, mk(164, 5, 2, 1, 131));
        tick = 1'b1; grow = 1'b1; dir_valid = 1'b1; dir_in = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        tick = 1'b0; grow = 1'b0; dir_valid = 1'b0;
        @(negedge clk); #1;
        chk("frozen_head", 32'(snake_head), 164);
        chk("frozen_len", 32'(length), 5);
        chk("frozen_dir", 32'(dir), 2);
        chk("frozen_dead", 32'(dead), 1);
        chk("frozen_tail", 32'(seg(4)), 131);
        do_reset();

        // Length-4 square: the head enters the cell the tail is leaving.
        step(1'b1, 1'b0, 2'd0, mk(133, 4, 0, 0, 130));
        step(1'b0, 1'b1, 2'd1, mk(165, 4, 1, 0, 131));
        step(1'b0, 1'b1, 2'd2, mk(164, 4, 2, 0, 132));
        step(1'b0, 1'b1, 2'd3, mk(132, 4, 3, 0, 133));

        // Reset raised in the middle of a tick cycle takes effect without a clock edge.
        tick = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_reset();
        @(posedge clk); #1;
        rst = 1'b0; tick = 1'b0;
        @(negedge clk); #1;

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
